motor_pwm_ctrl: RTL and testbench

- Parametrised N-channel DC-motor drive controller; successor to the fixed two-channel direction/enable glue in the platform top level.
- Per channel: PWM generation, soft-start duty ramp, dead-time on direction reversal, manual-run override, and a synchronised wheel-encoder event counter.
- Sits between the ibex_sys GPIO/register bank and the H-bridge pins (Mt*/EN*/Evnt).

---
 rtl/motor_pwm_ctrl.sv | 274 +++++++++++++++++++++++++++
 tb/tb_motor_pwm_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/motor_pwm_ctrl.sv
// -----------------------------------------------------------------------------
// motor_pwm_ctrl
// N-channel DC-motor drive controller. Each channel has PWM generation with a
// soft-start duty ramp, dead time on direction reversal, a manual-run override
// and a synchronised wheel-encoder event counter. The channels share one PWM
// timebase.
//
// Optional feature macro: MOTOR_STALL_DET_EN
//   When defined, this adds parameter STALL_CYC, output stall_o and a STALL
//   state. A channel that runs with non-zero duty and sees no encoder edge for
//   STALL_CYC cycles is shut off until its run request drops.
//
// Ports
//   clk_sys     system clock (only clock)
//   rst_sys     synchronous active-high reset
//   duty_i      target duty per channel, channel k at [k*PWM_W +: PWM_W]
//   dir_i       requested direction per channel
//   run_i       software run request per channel
//   btn_n       manual-run button, active-low, forces run on all channels
//   evnt_i      asynchronous encoder pulses per channel
//   cnt_clr_i   event counter clear per channel
//   mt_o        H-bridge direction pair per channel (dir 0 = 10, dir 1 = 01)
//   en_o        H-bridge enable (PWM) per channel
//   evnt_cnt_o  event count per channel, channel k at [k*EVC_W +: EVC_W]
//   busy_o      channel is not idle
//   stall_o     channel stalled (MOTOR_STALL_DET_EN only)
// -----------------------------------------------------------------------------
module motor_pwm_ctrl #(
  parameter int NCH       = 2,
  parameter int PWM_W     = 8,
  parameter int PWM_DIV   = 1,
  parameter int RAMP_STEP = 16,
  parameter int DEAD_CYC  = 64,
  parameter int EVC_W     = 16
`ifdef MOTOR_STALL_DET_EN
  ,
  parameter int STALL_CYC = 1048576
`endif
) (
  input  logic                 clk_sys,
  input  logic                 rst_sys,
  input  logic [NCH*PWM_W-1:0] duty_i,
  input  logic [NCH-1:0]       dir_i,
  input  logic [NCH-1:0]       run_i,
  input  logic                 btn_n,
  input  logic [NCH-1:0]       evnt_i,
  input  logic [NCH-1:0]       cnt_clr_i,
  output logic [2*NCH-1:0]     mt_o,
  output logic [NCH-1:0]       en_o,
  output logic [NCH*EVC_W-1:0] evnt_cnt_o,
  output logic [NCH-1:0]       busy_o
`ifdef MOTOR_STALL_DET_EN
  ,
  output logic [NCH-1:0]       stall_o
`endif
);

  localparam int PSC_W  = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  // Dead counter is loaded with DEAD_CYC-1 so EN stays low exactly DEAD_CYC cycles.
  localparam int DEAD_W = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
  localparam logic [PSC_W-1:0]  PSC_LAST  = PSC_W'(PWM_DIV - 1);
  localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYC - 1);
  localparam logic [PWM_W:0]    STEP      = (PWM_W + 1)'(RAMP_STEP);
`ifdef MOTOR_STALL_DET_EN
  localparam int TMR_W = $clog2(STALL_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LIM = TMR_W'(STALL_CYC);
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DEAD  = 2'd2
`ifdef MOTOR_STALL_DET_EN
    ,
    ST_STALL = 2'd3
`endif
  } state_e;

  // Move cur one step toward tgt, landing exactly on tgt instead of overshooting.
  function automatic logic [PWM_W-1:0] ramp_f(input logic [PWM_W-1:0] cur,
                                               input logic [PWM_W-1:0] tgt);
    logic [PWM_W:0] gap;
    if (tgt > cur) begin
      gap = {1'b0, tgt} - {1'b0, cur};
      if (gap > STEP) ramp_f = cur + STEP[PWM_W-1:0];
      else            ramp_f = tgt;
    end else begin
      gap = {1'b0, cur} - {1'b0, tgt};
      if (gap > STEP) ramp_f = cur - STEP[PWM_W-1:0];
      else            ramp_f = tgt;
    end
  endfunction

  logic [PSC_W-1:0]  psc_q, psc_d;
  logic [PWM_W-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic              tick_s, period_end_s;
  state_e            state_q [NCH];
  state_e            state_d [NCH];
  logic [PWM_W-1:0]  duty_q [NCH];
  logic [PWM_W-1:0]  duty_d [NCH];
  logic [DEAD_W-1:0] dead_q [NCH];
  logic [DEAD_W-1:0] dead_d [NCH];
  logic [EVC_W-1:0]  evc_q [NCH];
  logic [EVC_W-1:0]  evc_d [NCH];
  logic [NCH-1:0]    dir_q, dir_d, en_q, en_d, busy_q, busy_d;
  logic [NCH-1:0]    sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
  logic [NCH-1:0]    go_s, rise_s;
`ifdef MOTOR_STALL_DET_EN
  logic [TMR_W-1:0]  tmr_q [NCH];
  logic [TMR_W-1:0]  tmr_d [NCH];
  logic [NCH-1:0]    stall_q, stall_d;
`endif

  assign go_s = run_i | {NCH{~btn_n}};

  // Shared prescaler and PWM counter; period end is the tick that wraps to 0.
  always_comb begin
    tick_s = (psc_q == PSC_LAST);
    if (tick_s) begin
      psc_d     = '0;
      pwm_cnt_d = pwm_cnt_q + PWM_W'(1'b1);
    end else begin
      psc_d     = psc_q + PSC_W'(1'b1);
      pwm_cnt_d = pwm_cnt_q;
    end
    period_end_s = tick_s & (&pwm_cnt_q);
  end

  // Encoder 2-FF synchroniser, rising-edge detect and per-channel counter.
  always_comb begin
    sync1_d = evnt_i;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
    rise_s  = sync2_q & ~sync3_q;
    for (int k = 0; k < NCH; k++) begin
      if (cnt_clr_i[k])   evc_d[k] = '0;
      else if (rise_s[k]) evc_d[k] = evc_q[k] + EVC_W'(1'b1);
      else                evc_d[k] = evc_q[k];
    end
  end

  // Per-channel FSM, duty ramp, dead timer and registered output terms.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      state_d[k] = state_q[k];
      duty_d[k]  = duty_q[k];
      dead_d[k]  = dead_q[k];
      dir_d[k]   = dir_q[k];
      case (state_q[k])
        ST_IDLE: begin
          duty_d[k] = '0;
          dir_d[k]  = dir_i[k];
          if (go_s[k]) state_d[k] = ST_RUN;
          else         state_d[k] = ST_IDLE;
        end
        ST_RUN: begin
          if (!go_s[k]) begin
            state_d[k] = ST_IDLE;
            duty_d[k]  = '0;
          end else if (dir_i[k] != dir_q[k]) begin
            state_d[k] = ST_DEAD;
            duty_d[k]  = '0;
            dead_d[k]  = DEAD_LOAD;
`ifdef MOTOR_STALL_DET_EN
          end else if (tmr_q[k] == TMR_LIM) begin
            state_d[k] = ST_STALL;
            duty_d[k]  = '0;
`endif
          end else if (period_end_s) begin
            duty_d[k] = ramp_f(duty_q[k], duty_i[k*PWM_W +: PWM_W]);
          end else begin
            duty_d[k] = duty_q[k];
          end
        end
        ST_DEAD: begin
          duty_d[k] = '0;
          if (!go_s[k]) begin
            state_d[k] = ST_IDLE;
          end else if (dead_q[k] == '0) begin
            // Direction is taken from the final sample, whatever toggling happened.
            state_d[k] = ST_RUN;
            dir_d[k]   = dir_i[k];
          end else begin
            dead_d[k] = dead_q[k] - DEAD_W'(1'b1);
          end
        end
`ifdef MOTOR_STALL_DET_EN
        ST_STALL: begin
          duty_d[k] = '0;
          if (!go_s[k]) state_d[k] = ST_IDLE;
          else          state_d[k] = ST_STALL;
        end
`endif
        default: begin
          state_d[k] = ST_IDLE;
          duty_d[k]  = '0;
        end
      endcase
      // Gating with the next state drops EN together with the state change.
      en_d[k]   = (state_d[k] == ST_RUN) & (pwm_cnt_q < duty_q[k]);
      busy_d[k] = (state_d[k] != ST_IDLE);
`ifdef MOTOR_STALL_DET_EN
      stall_d[k] = (state_d[k] == ST_STALL);
      if ((state_q[k] != ST_RUN) || rise_s[k]) tmr_d[k] = '0;
      else if ((duty_q[k] != '0) && (tmr_q[k] != TMR_LIM)) tmr_d[k] = tmr_q[k] + TMR_W'(1'b1);
      else tmr_d[k] = tmr_q[k];
`endif
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      psc_q     <= '0;
      pwm_cnt_q <= '0;
      dir_q     <= '0;
      en_q      <= '0;
      busy_q    <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      sync3_q   <= '0;
      for (int k = 0; k < NCH; k++) begin
        state_q[k] <= ST_IDLE;
        duty_q[k]  <= '0;
        dead_q[k]  <= '0;
        evc_q[k]   <= '0;
`ifdef MOTOR_STALL_DET_EN
        tmr_q[k]   <= '0;
`endif
      end
`ifdef MOTOR_STALL_DET_EN
      stall_q <= '0;
`endif
    end else begin
      psc_q     <= psc_d;
      pwm_cnt_q <= pwm_cnt_d;
      dir_q     <= dir_d;
      en_q      <= en_d;
      busy_q    <= busy_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      sync3_q   <= sync3_d;
      for (int k = 0; k < NCH; k++) begin
        state_q[k] <= state_d[k];
        duty_q[k]  <= duty_d[k];
        dead_q[k]  <= dead_d[k];
        evc_q[k]   <= evc_d[k];
`ifdef MOTOR_STALL_DET_EN
        tmr_q[k]   <= tmr_d[k];
`endif
      end
`ifdef MOTOR_STALL_DET_EN
      stall_q <= stall_d;
`endif
    end
  end

  // Output packing from registered state.
  always_comb begin
    mt_o       = '0;
    evnt_cnt_o = '0;
    for (int k = 0; k < NCH; k++) begin
      mt_o[2*k +: 2]             = {~dir_q[k], dir_q[k]};
      evnt_cnt_o[k*EVC_W +: EVC_W] = evc_q[k];
    end
  end

  assign en_o   = en_q;
  assign busy_o = busy_q;
`ifdef MOTOR_STALL_DET_EN
  assign stall_o = stall_q;
`endif

endmodule

// File: tb/tb_motor_pwm_ctrl.sv
// -----------------------------------------------------------------------------
// tb_motor_pwm_ctrl
// Directed bench for motor_pwm_ctrl: reset values, soft-start ramp up and down,
// reversal dead time, manual override, encoder counting, clear and wrap, reset
// mid-run and (with MOTOR_STALL_DET_EN) stall detection. The event counter is
// built 8 bits wide so that counter wrap is reachable in a short run.
// -----------------------------------------------------------------------------
module tb_motor_pwm_ctrl;
  localparam int NCH   = 2;
  localparam int PWM_W = 8;
  localparam int EVC_W = 8;

  logic                 clk_sys = 1'b0;
  logic                 rst_sys;
  logic [NCH*PWM_W-1:0] duty_i;
  logic [NCH-1:0]       dir_i, run_i, evnt_i, cnt_clr_i;
  logic                 btn_n;
  logic [2*NCH-1:0]     mt_o;
  logic [NCH-1:0]       en_o, busy_o;
  logic [NCH*EVC_W-1:0] evnt_cnt_o;
`ifdef MOTOR_STALL_DET_EN
  logic [NCH-1:0]       stall_o;
`endif

  int checks = 0;
  int errors = 0;
  int c0, c1, n;

  // Independent model of the shared PWM counter (advances every cycle, PWM_DIV=1).
  logic [7:0] mcnt = 8'd0;

  motor_pwm_ctrl #(
    .NCH(NCH), .PWM_W(PWM_W), .PWM_DIV(1), .RAMP_STEP(16), .DEAD_CYC(8), .EVC_W(EVC_W)
`ifdef MOTOR_STALL_DET_EN
    , .STALL_CYC(1000)
`endif
  ) dut (
    .clk_sys(clk_sys), .rst_sys(rst_sys), .duty_i(duty_i), .dir_i(dir_i),
    .run_i(run_i), .btn_n(btn_n), .evnt_i(evnt_i), .cnt_clr_i(cnt_clr_i),
    .mt_o(mt_o), .en_o(en_o), .evnt_cnt_o(evnt_cnt_o), .busy_o(busy_o)
`ifdef MOTOR_STALL_DET_EN
    , .stall_o(stall_o)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) begin
    if (rst_sys) mcnt <= 8'd0;
    else         mcnt <= mcnt + 8'd1;
  end

  task automatic step(input int cyc);
    repeat (cyc) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic sync_to(input logic [7:0] m);
    int guard;
    guard = 0;
    while ((mcnt != m) && (guard < 600)) begin
      step(1);
      guard++;
    end
    if (mcnt != m) begin
      errors++;
      $error("FAIL sync_timeout observed=%0d expected=%0d", mcnt, m);
    end
  endtask

  // Count EN high cycles over one PWM period (samples reflect counts 0..255).
  task automatic measure(output int h0, output int h1);
    sync_to(8'd1);
    h0 = 0;
    h1 = 0;
    repeat (256) begin
      h0 += int'(en_o[0]);
      h1 += int'(en_o[1]);
      step(1);
    end
  endtask

  task automatic pulse(input int ch, input int hi, input int lo);
    evnt_i[ch] = 1'b1;
    step(hi);
    evnt_i[ch] = 1'b0;
    step(lo);
  endtask

  initial begin
    rst_sys = 1'b1; duty_i = 16'd0; dir_i = 2'b00; run_i = 2'b00;
    btn_n = 1'b1; evnt_i = 2'b00; cnt_clr_i = 2'b00;
    #1;
    step(3);
    chk("rst_en",   32'(en_o),       32'd0);
    chk("rst_mt",   32'(mt_o),       32'b1010);
    chk("rst_cnt",  32'(evnt_cnt_o), 32'd0);
    chk("rst_busy", 32'(busy_o),     32'd0);
    rst_sys = 1'b0;

    // Soft start on channel 0 toward 64.
    duty_i[7:0] = 8'd64;
    sync_to(8'd1);
    run_i[0] = 1'b1;
    step(1);
    chk("ss_busy", 32'(busy_o), 32'b01);
    measure(c0, c1); chk("ss_p1", 32'(c0), 32'd16);
    measure(c0, c1); chk("ss_p2", 32'(c0), 32'd32);
    measure(c0, c1); chk("ss_p3", 32'(c0), 32'd48);
    measure(c0, c1); chk("ss_p4", 32'(c0), 32'd64);
    chk("ss_ch1_off", 32'(c1), 32'd0);
    // Ramp down to 40 must not undershoot.
    duty_i[7:0] = 8'd40;
    measure(c0, c1); chk("dn_p0", 32'(c0), 32'd64);
    measure(c0, c1); chk("dn_p1", 32'(c0), 32'd48);
    measure(c0, c1); chk("dn_p2", 32'(c0), 32'd40);

    // Channel 1 ramps to 128, then reverses.
    duty_i[15:8] = 8'd128;
    run_i[1] = 1'b1;
    step(1);
    repeat (8) measure(c0, c1);
    chk("rv_ch1_128", 32'(c1), 32'd128);
    chk("rv_ch0_40",  32'(c0), 32'd40);
    step(10);
    chk("rv_en_pre", 32'(en_o[1]), 32'd1);
    dir_i[1] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk($sformatf("rv_dead%0d", i), 32'({en_o[1], mt_o[3:2], busy_o[1]}), 32'b0101);
    end
    step(1);
    chk("rv_mt_new", 32'(mt_o[3:2]), 32'b01);
    chk("rv_busy",   32'(busy_o[1]), 32'd1);
    measure(c0, c1);
    chk("rv_restart16", 32'(c1), 32'd16);

    // Manual override via btn_n.
    run_i = 2'b00;
    step(2);
    chk("mo_idle_busy", 32'(busy_o), 32'd0);
    chk("mo_idle_en",   32'(en_o),   32'd0);
    duty_i = 16'hFFFF;
    btn_n = 1'b0;
    step(1);
    chk("mo_busy", 32'(busy_o), 32'b11);
    repeat (15) measure(c0, c1);
    chk("mo_240", 32'(c0), 32'd240);
    measure(c0, c1);
    chk("mo_255_ch0", 32'(c0), 32'd255);
    chk("mo_255_ch1", 32'(c1), 32'd255);
    sync_to(8'd50);
    chk("mo_en_hi", 32'(en_o), 32'b11);
    btn_n = 1'b1;
    step(1);
    chk("mo_rel_en",   32'(en_o),   32'd0);
    chk("mo_rel_busy", 32'(busy_o), 32'd0);

    // Encoder: 5 pulses, then a clear coincident with the 6th edge.
    repeat (5) pulse(0, 4, 4);
    chk("enc_5",     32'(evnt_cnt_o[7:0]),  32'd5);
    chk("enc_ch1_0", 32'(evnt_cnt_o[15:8]), 32'd0);
    evnt_i[0] = 1'b1;
    step(2);
    chk("enc_pre_clr", 32'(evnt_cnt_o[7:0]), 32'd5);
    cnt_clr_i[0] = 1'b1;
    step(1);
    cnt_clr_i[0] = 1'b0;
    chk("enc_clr", 32'(evnt_cnt_o[7:0]), 32'd0);
    step(1);
    evnt_i[0] = 1'b0;
    step(6);
    chk("enc_clr_hold", 32'(evnt_cnt_o[7:0]), 32'd0);
    repeat (3) pulse(1, 4, 4);
    chk("enc_ch1_3", 32'(evnt_cnt_o[15:8]), 32'd3);
    repeat (259) pulse(0, 2, 2);
    step(4);
    chk("enc_wrap", 32'(evnt_cnt_o[7:0]), 32'd3);

    // Reset in the middle of operation.
    duty_i = {8'd100, 8'd100};
    dir_i = 2'b10;
    run_i = 2'b11;
    measure(c0, c1);
    measure(c0, c1);
    sync_to(8'd10);
    chk("mr_en_pre", 32'(en_o), 32'b11);
    chk("mr_mt_pre", 32'(mt_o), 32'b0110);
    rst_sys = 1'b1;
    step(1);
    chk("mr_en",   32'(en_o),       32'd0);
    chk("mr_mt",   32'(mt_o),       32'b1010);
    chk("mr_cnt",  32'(evnt_cnt_o), 32'd0);
    chk("mr_busy", 32'(busy_o),     32'd0);
    rst_sys = 1'b0;
    run_i = 2'b00;
    dir_i = 2'b00;
    step(2);

`ifdef MOTOR_STALL_DET_EN
    // Stall: running with no encoder edges.
    duty_i[7:0] = 8'd64;
    run_i = 2'b01;
    n = 0;
    while ((stall_o[0] !== 1'b1) && (n < 3000)) begin
      step(1);
      n++;
    end
    chk("st_set",  32'(stall_o[0]), 32'd1);
    chk("st_time", 32'((n >= 1000) && (n <= 1300)), 32'd1);
    step(3);
    chk("st_en",   32'(en_o[0]),   32'd0);
    chk("st_busy", 32'(busy_o[0]), 32'd1);
    run_i = 2'b00;
    step(1);
    chk("st_clr",  32'(stall_o[0]), 32'd0);
    chk("st_idle", 32'(busy_o[0]),  32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
